// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter for the rv32im core.
// Holds the fetch PC, issues it to instruction memory over a valid/ready
// request, and handles stall, redirect (with a misalignment trap),
// halt/resume and a one-cycle boot state after reset.
module pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
    parameter int unsigned     STEP         = 4
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            halt_req_i,
    input  logic            resume_i,
    input  logic            imem_req_ready_i,
    output logic            imem_req_valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_step_o,
    output logic            halted_o,
    output logic            misalign_err_o,
    output logic [XLEN-1:0] misalign_addr_o
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] addr_q, addr_d;

    logic            req_valid;
    logic            accept;
    logic            req_resolved;
    logic            misaligned;

    // Sequential PC increment; wraps modulo 2^XLEN with no overflow flag.
    assign pc_plus_step_o = pc_q + XLEN'(STEP);

    // A request is only offered in RUN and never while stalled or in reset.
    assign req_valid    = (state_q == ST_RUN) && !stall_i && !reset_i;
    assign accept       = req_valid && imem_req_ready_i;
    // Nothing outstanding: either no request this cycle or it is taken now.
    assign req_resolved = !req_valid || accept;
    // Only word alignment is enforced on redirect targets.
    assign misaligned   = |redirect_target_i[1:0];

    assign imem_req_valid_o = req_valid;
    assign pc_o             = pc_q;
    assign halted_o         = (state_q == ST_HALT);
    assign misalign_err_o   = err_q;
    assign misalign_addr_o  = addr_q;

    // Next-state: redirect beats stall and accept; a redirect also discards
    // any in-flight request, so a coincident halt_req may enter HALT at once.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = 1'b0;
        addr_d  = addr_q;

        if (redirect_valid_i) begin
            if (misaligned) begin
                pc_d   = TRAP_VECTOR;
                err_d  = 1'b1;
                addr_d = redirect_target_i;
            end else begin
                pc_d = redirect_target_i;
            end
        end else if (accept) begin
            pc_d = pc_plus_step_o;
        end

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (halt_req_i && (redirect_valid_i || req_resolved))
                    state_d = ST_HALT;
            end
            ST_HALT: begin
                // A redirect while halted moves the PC but keeps us halted.
                if (resume_i && !redirect_valid_i)
                    state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // State registers with synchronous reset overriding every other input.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            err_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
        end
    end

endmodule
